// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a registered result.
// Handles one operation at a time and aligns the combinational carry with the registered result.
module alu_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // Handshake: a transfer occurs at a rising edge where valid and ready are both 1.
    // Requesters hold payload while valid && !ready. Responses are held unchanged while resp_valid && !resp_ready.
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [2:0]           req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic [2:0]           req1_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [WIDTH-1:0]     resp_data,
    output logic                 resp_cout,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_cout,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] ops_done,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd4;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last;
    logic                  r_id;
    logic                  r_cout_q;
    logic [WIDTH-1:0]      r_alu_a;
    logic [WIDTH-1:0]      r_alu_b;
    logic [2:0]            r_alu_op;
    logic [CNT_WIDTH-1:0]  r_ops_done;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_resp_fire;

    // r_last names the requester served most recently; the other one wins a tie.
    always_comb begin
        w_next_state = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant0 = req0_valid && (!req1_valid || r_last);
                w_grant1 = req1_valid && (!req0_valid || !r_last);
                if (w_grant0 || w_grant1) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept    = w_grant0 || w_grant1;
    assign w_resp_fire = (r_state == RESP) && resp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_cout_q   <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_ops_done <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_alu_a  <= w_grant1 ? req1_a  : req0_a;
                r_alu_b  <= w_grant1 ? req1_b  : req0_b;
                r_alu_op <= w_grant1 ? req1_op : req0_op;
                r_id     <= w_grant1;
                r_last   <= w_grant1;
            end
            // Carry is combinational on the held operands; capture it alongside the ALU's result flop.
            if (r_state == EXEC) begin
                r_cout_q <= alu_cout;
            end
            if (w_resp_fire) begin
                r_ops_done <= r_ops_done + CNT_WIDTH'(1);
            end
        end
    end

    // Operands stay held through RESP, so alu_result is stable while the response stalls.
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign resp_valid = (r_state == RESP);
    assign resp_data  = resp_valid ? alu_result : '0;
    assign resp_id    = resp_valid && r_id;
    assign resp_cout  = resp_valid && (r_alu_op == OP_ADD) && r_cout_q;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign busy       = (r_state != IDLE);
    assign ops_done   = r_ops_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two DUTs (16-bit and 2-bit counters) share stimulus, each with a behavioural ALU.
// A negedge scoreboard predicts grants, response timing and payloads from the arbitration rules.
module tb_alu_arbiter;

    localparam int W  = 8;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           req0_valid = 1'b0;
    logic           req1_valid = 1'b0;
    logic           resp_ready = 1'b0;
    logic [W-1:0]   req0_a = '0;
    logic [W-1:0]   req0_b = '0;
    logic [W-1:0]   req1_a = '0;
    logic [W-1:0]   req1_b = '0;
    logic [2:0]     req0_op = '0;
    logic [2:0]     req1_op = '0;

    logic           req0_ready, req1_ready, resp_valid, resp_id, resp_cout, busy, alu_cout;
    logic [W-1:0]   resp_data, alu_a, alu_b;
    logic [W-1:0]   alu_result;
    logic [2:0]     alu_op;
    logic [CW-1:0]  ops_done;
    logic [1:0]     dbg_state;
    logic [W:0]     alu_comb;

    logic           c2_req0_ready, c2_req1_ready, c2_resp_valid, c2_resp_id, c2_resp_cout, c2_busy, c2_alu_cout;
    logic [W-1:0]   c2_resp_data, c2_alu_a, c2_alu_b;
    logic [W-1:0]   c2_alu_result;
    logic [2:0]     c2_alu_op;
    logic [1:0]     c2_ops_done;
    logic [1:0]     c2_dbg_state;
    logic [W:0]     c2_alu_comb;

    int             checks = 0;
    int             errors = 0;

    logic [W+1:0]   exp_q[$];
    int             acc_log[$];
    logic           m_inflight = 1'b0;
    logic           m_resp = 1'b0;
    logic           m_last = 1'b1;
    int             m_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_cout(resp_cout), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_cout(alu_cout), .busy(busy), .ops_done(ops_done), .dbg_state(dbg_state)
    );

    alu_arbiter #(.WIDTH(W), .CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(c2_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(c2_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(c2_resp_valid), .resp_ready(resp_ready), .resp_id(c2_resp_id), .resp_data(c2_resp_data),
        .resp_cout(c2_resp_cout), .alu_a(c2_alu_a), .alu_b(c2_alu_b), .alu_op(c2_alu_op), .alu_result(c2_alu_result),
        .alu_cout(c2_alu_cout), .busy(c2_busy), .ops_done(c2_ops_done), .dbg_state(c2_dbg_state)
    );

    // Behavioural ALU: unreset result flop, combinational carry from an adder.
    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        logic [W:0] r;
        r = '0;
        case (op)
            3'd0:    r = {1'b0, a & b};
            3'd1:    r = {1'b0, a | b};
            3'd2:    r = {1'b0, a ^ b};
            3'd3:    r = {1'b0, ~a};
            3'd4:    r = {1'b0, a} + {1'b0, b};
            3'd5:    r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            3'd6:    r = {1'b0, a} + {1'b0, {W{1'b1}}};
            default: r = {1'b0, a} + (W+1)'(1);
        endcase
        return r;
    endfunction

    assign alu_comb    = alu_fn(alu_a, alu_b, alu_op);
    assign alu_cout    = alu_comb[W];
    assign c2_alu_comb = alu_fn(c2_alu_a, c2_alu_b, c2_alu_op);
    assign c2_alu_cout = c2_alu_comb[W];

    always @(posedge clk) begin
        alu_result    <= alu_comb[W-1:0];
        c2_alu_result <= c2_alu_comb[W-1:0];
    end

    function automatic logic [W-1:0] ref_data(input int a, input int b, input int op);
        int m;
        m = 1 << W;
        case (op)
            0:       return W'(a & b);
            1:       return W'(a | b);
            2:       return W'(a ^ b);
            3:       return W'(m - 1 - a);
            4:       return W'((a + b) % m);
            5:       return W'((a - b + m) % m);
            6:       return W'((a + m - 1) % m);
            default: return W'((a + 1) % m);
        endcase
    endfunction

    function automatic logic ref_cout(input int a, input int b, input int op);
        return (op == 4) && (a + b >= (1 << W));
    endfunction

    // Scoreboard: predicts grants and response timing, queues expected {id, cout, data}.
    always @(negedge clk) begin
        logic e_g0, e_g1, e_rv;
        logic [W+1:0] e_front;
        int ga, gb, gop;
        if (!reset_n) begin
            exp_q.delete();
            m_inflight = 1'b0;
            m_resp     = 1'b0;
            m_last     = 1'b1;
            m_cnt      = 0;
        end else begin
            e_g0 = !m_inflight && req0_valid && (!req1_valid || m_last);
            e_g1 = !m_inflight && req1_valid && (!req0_valid || !m_last);
            e_rv = m_resp;
            checks++;
            if ({req0_ready, req1_ready, c2_req0_ready, c2_req1_ready} !== {e_g0, e_g1, e_g0, e_g1}) begin
                errors++;
                $display("FAIL ready: got %b%b/%b%b, expected %b%b", req0_ready, req1_ready,
                         c2_req0_ready, c2_req1_ready, e_g0, e_g1);
            end
            checks++;
            if ({resp_valid, c2_resp_valid} !== {e_rv, e_rv}) begin
                errors++;
                $display("FAIL resp_valid: got %b/%b, expected %b", resp_valid, c2_resp_valid, e_rv);
            end
            checks++;
            if ({busy, c2_busy} !== {m_inflight, m_inflight}) begin
                errors++;
                $display("FAIL busy: got %b/%b, expected %b", busy, c2_busy, m_inflight);
            end
            checks++;
            if (ops_done !== CW'(m_cnt) || c2_ops_done !== 2'(m_cnt)) begin
                errors++;
                $display("FAIL ops_done: got %0d/%0d, expected %0d/%0d", ops_done, c2_ops_done,
                         CW'(m_cnt), 2'(m_cnt));
            end
            if (e_rv) begin
                e_front = (exp_q.size() > 0) ? exp_q[0] : 'x;
                checks++;
                if ({resp_id, resp_cout, resp_data} !== e_front) begin
                    errors++;
                    $display("FAIL resp_payload: got id=%b cout=%b data=%h, expected id=%b cout=%b data=%h",
                             resp_id, resp_cout, resp_data, e_front[W+1], e_front[W], e_front[W-1:0]);
                end
                checks++;
                if ({c2_resp_id, c2_resp_cout, c2_resp_data} !== e_front) begin
                    errors++;
                    $display("FAIL c2_resp_payload: got id=%b cout=%b data=%h, expected id=%b cout=%b data=%h",
                             c2_resp_id, c2_resp_cout, c2_resp_data, e_front[W+1], e_front[W], e_front[W-1:0]);
                end
            end
            if (e_g0 || e_g1) begin
                ga  = e_g1 ? int'(req1_a)  : int'(req0_a);
                gb  = e_g1 ? int'(req1_b)  : int'(req0_b);
                gop = e_g1 ? int'(req1_op) : int'(req0_op);
                exp_q.push_back({e_g1, ref_cout(ga, gb, gop), ref_data(ga, gb, gop)});
                acc_log.push_back(e_g1 ? 1 : 0);
                m_inflight = 1'b1;
                m_resp     = 1'b0;
                m_last     = e_g1;
            end else if (m_inflight && !m_resp) begin
                m_resp = 1'b1;
            end else if (m_resp && resp_ready) begin
                void'(exp_q.pop_front());
                m_inflight = 1'b0;
                m_resp     = 1'b0;
                m_cnt++;
            end
        end
    end

    task automatic wait_grant(input int n);
        int k;
        k = 0;
        @(negedge clk);
        while (!((n == 0 && req0_ready === 1'b1) || (n == 1 && req1_ready === 1'b1)) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: requester %0d not granted within 50 cycles, expected a grant", n);
        end
    endtask

    task automatic wait_resp();
        int k;
        k = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: resp_valid=%b after 50 cycles, expected 1", resp_valid);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b after 60 cycles, expected 0", busy);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, resp_valid, req0_ready, req1_ready, alu_a, alu_b, alu_op, ops_done, resp_data, resp_id, resp_cout}
            !== '0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b rv=%b a=%h b=%h op=%h cnt=%0d data=%h, expected all 0",
                     busy, resp_valid, alu_a, alu_b, alu_op, ops_done, resp_data);
        end
        reset_n = 1'b1;
        // Reset arrives while an ADD sits in EXEC.
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h20; req0_op = 3'd4;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL exec_busy: got %b, expected 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, resp_valid, alu_a, alu_b, alu_op, ops_done, c2_busy, c2_ops_done} !== '0) begin
            errors++;
            $display("FAIL mid_exec_reset: got busy=%b rv=%b a=%h b=%h op=%h cnt=%0d, expected all 0",
                     busy, resp_valid, alu_a, alu_b, alu_op, ops_done);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid, c2_resp_valid} !== 2'b00) begin
                errors++;
                $display("FAIL discarded_op: got resp_valid=%b/%b, expected 0", resp_valid, c2_resp_valid);
            end
        end
    endtask

    task automatic test_single_add();
        int base;
        @(posedge clk);
        #1;
        base = m_cnt;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h20; req0_op = 3'd4;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ready: got %b, expected 1", req0_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_latency_early: got resp_valid=%b, expected 0", resp_valid);
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_id, resp_cout, resp_data} !== {1'b1, 1'b0, 1'b1, 8'h10}) begin
            errors++;
            $display("FAIL add_resp: got rv=%b id=%b cout=%b data=%h, expected rv=1 id=0 cout=1 data=10",
                     resp_valid, resp_id, resp_cout, resp_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ops_done !== CW'(base + 1)) begin
            errors++;
            $display("FAIL add_ops_done: got %0d, expected %0d", ops_done, base + 1);
        end
    endtask

    task automatic test_sub();
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h07; req1_op = 3'd5;
        wait_grant(1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_resp();
        checks++;
        if ({resp_id, resp_cout, resp_data} !== {1'b1, 1'b0, 8'hFE}) begin
            errors++;
            $display("FAIL sub_resp: got id=%b cout=%b data=%h, expected id=1 cout=0 data=fe",
                     resp_id, resp_cout, resp_data);
        end
        wait_idle();
    endtask

    task automatic test_arbitration();
        int n, k;
        logic g0, g1;
        @(posedge clk);
        #1;
        acc_log.delete();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 3'($urandom_range(0, 7));
        req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 3'($urandom_range(0, 7));
        n = 0;
        k = 0;
        while (n < 4 && k < 100) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            @(posedge clk);
            #1;
            if (g0 === 1'b1) begin
                n++;
                req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 3'($urandom_range(0, 7));
            end
            if (g1 === 1'b1) begin
                n++;
                req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 3'($urandom_range(0, 7));
            end
            k++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (acc_log.size() != 4) begin
            errors++;
            $display("FAIL arb_count: got %0d grants, expected 4", acc_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_log[i] != i % 2) begin
                    errors++;
                    $display("FAIL arb_order[%0d]: got id %0d, expected %0d", i, acc_log[i], i % 2);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int base;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h0F; req0_op = 3'd2;
        wait_grant(0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 3'($urandom_range(0, 7));
        wait_resp();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({resp_valid, resp_id, resp_data, req0_ready, req1_ready} !== {1'b1, 1'b0, 8'h33, 2'b00}) begin
                errors++;
                $display("FAIL stall[%0d]: got rv=%b id=%b data=%h rdy=%b%b, expected rv=1 id=0 data=33 rdy=00",
                         i, resp_valid, resp_id, resp_data, req0_ready, req1_ready);
            end
        end
        @(posedge clk);
        #1;
        base = m_cnt;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, ops_done} !== {1'b0, CW'(base + 1)}) begin
            errors++;
            $display("FAIL stall_release: got busy=%b cnt=%0d, expected busy=0 cnt=%0d", busy, ops_done, base + 1);
        end
        wait_grant(1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_counter_wrap();
        logic [W-1:0] ta[5]  = '{8'hFF, 8'hAA, 8'h12, 8'h80, 8'h00};
        logic [W-1:0] tb[5]  = '{8'h00, 8'h00, 8'h34, 8'h80, 8'h01};
        logic [2:0]   top[5] = '{3'd7, 3'd3, 3'd2, 3'd4, 3'd5};
        logic [1:0]   seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        pulse_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i]; req0_op = top[i];
            wait_grant(0);
            @(posedge clk);
            #1 req0_valid = 1'b0;
            wait_resp();
            @(posedge clk);
            #1;
            checks++;
            if (c2_ops_done !== seq[i]) begin
                errors++;
                $display("FAIL wrap[%0d]: got ops_done=%0d, expected %0d", i, c2_ops_done, seq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic g0, g1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            @(posedge clk);
            #1;
            if (g0 === 1'b1 || !req0_valid) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 3'($urandom_range(0, 7));
            end
            if (g1 === 1'b1 || !req1_valid) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 3'($urandom_range(0, 7));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub();
        test_arbitration();
        test_backpressure();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester front end that shares a single `alu` instance (WIDTH-bit, 3-bit alucontrol, registered result, combinational cout).
- Accepts operation requests over valid/ready, arbitrates round-robin, and drives the ALU operands and opcode.
- Aligns the combinational carry with the registered result and returns a tagged response over valid/ready.
- Sits between instruction-issue logic and the ALU datapath; only one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; must match the attached alu.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  3  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as the req0 signals, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_id  out  1  requester index of the result.
- resp_data  out  WIDTH  ALU result.
- resp_cout  out  1  carry out; valid for add only.
- alu_a, alu_b  out  WIDTH  to alu a, b.
- alu_op  out  3  to alu alucontrol.
- alu_result  in  WIDTH  from alu result (registered inside alu).
- alu_cout  in  1  from alu cout (combinational on a, b).
- busy  out  1  state != IDLE.
- ops_done  out  CNT_WIDTH  count of completed responses.

Behaviour:
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT a, 4 ADD, 5 SUB, 6 DEC, 7 INC.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: alu_a, alu_b, alu_op, resp_data, resp_id, resp_cout, ops_done = 0; all ready and valid outputs = 0; RR pointer last = 1, so req0 wins first.
- IDLE, arbitration: if exactly one reqN_valid, grant N. If both, grant the requester that is not last. The grant asserts reqN_ready combinationally in the same cycle; the other ready stays 0.
- IDLE, on grant at edge t: register operands and op into alu_a/alu_b/alu_op; record id; set last = N; go to EXEC. If no valid, stay in IDLE.
- EXEC (one cycle):
  - Operands are stable on the ALU and the alu flop captures at the end of this cycle.
  - Sample alu_cout into cout_q at this edge. Required because alu_cout is combinational and the result is registered.
  - Go to RESP.
- RESP:
  - resp_valid = 1; resp_data = alu_result; resp_id = recorded id; resp_cout = cout_q when alu_op==4, else 0.
  - Operand registers are held, so alu_result stays stable.
  - When resp_ready = 1 at an edge: increment ops_done, go to IDLE.
  - Otherwise hold all resp outputs unchanged (no drop, no change while stalled).
- Latency: accept edge t → resp_valid high during cycle t+2 (minimum). Minimum initiation interval is 3 cycles; no acceptance in EXEC or RESP (both ready = 0).
- Requester contract: req payload must be held stable while valid and not ready. The arbiter does not depend on it, because it samples only at grant.
- Round-robin: under continuous dual requests, grants alternate 0, 1, 0, 1…. A single active requester is granted every opportunity.
- ops_done wraps modulo 2^CNT_WIDTH.
- Reset mid-operation (any state): asynchronous return to IDLE with reset values. Any in-flight result is discarded and no response is issued. The alu internal flop is unreset; alu_result is never exposed outside RESP, so X after reset is invisible.
- Simultaneous resp_ready and a new req_valid in RESP: the response completes, and the new request is not accepted until the following IDLE cycle.

Test Plan:
- Reset: assert reset_n=0 mid-EXEC with req0 ADD pending → next cycle state IDLE; busy=0, resp_valid=0, alu_a=alu_b=alu_op=0, ops_done=0; no response is ever produced for that op.
- Single ADD, WIDTH=8: req0 a=0xF0, b=0x20, op=4 accepted at t → resp_valid at t+2; resp_data=0x10, resp_cout=1, resp_id=0; ops_done=1 after handshake.
- SUB with no carry reporting: req1 a=0x05, b=0x07, op=5 → resp_data=0xFE, resp_cout=0, resp_id=1.
- Arbitration: req0 and req1 both held valid for 4 operations → accepted ids 0, 1, 0, 1; each ready pulse lasts exactly one cycle and only in IDLE.
- Backpressure: resp_ready=0 for 5 cycles on an XOR result (0x3C ^ 0x0F = 0x33) → resp_valid, resp_data and resp_id stable all 5 cycles; both req_ready=0; completion occurs on the cycle resp_ready=1.
- Counter wrap, CNT_WIDTH=2: complete 5 operations (INC 0xFF → 0x00, NOT 0xAA → 0x55, …) → ops_done sequence 1, 2, 3, 0, 1.
